mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and data memory.
// Data wins contention unless fetch has been starved STARVE_MAX times in a row.
// Responses follow the grant by one cycle and are routed to the recorded owner.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    input  logic        halt,
    output logic        stall_if,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   starve_cnt_q;
    logic [CNT_W-1:0]   starve_cnt_d;
    logic               resp_valid_q;
    logic               resp_owner_q;   // 1 = data port, 0 = fetch
    logic               resp_we_q;
    logic               running;
    logic               starved;

    assign running = (state_q == RUN);
    assign starved = (starve_cnt_q == CNT_W'(STARVE_MAX));

    // Grant selection: fetch only in RUN, and only when uncontested or starved
    always_comb begin
        if_gnt   = running & if_req & (~dm_req | starved);
        dm_gnt   = dm_req & ~if_gnt;
        stall_if = if_req & ~if_gnt;
    end

    // Drive the shared memory port from the winner, zero when idle
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (dm_gnt) begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Starvation counter next value: saturating, cleared when fetch is served or idle
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (dm_req && dm_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // FSM, starvation counter and response-owner tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            starve_cnt_q <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            if (running && halt) begin
                state_q <= HALTED;
            end
            starve_cnt_q <= starve_cnt_d;
            resp_valid_q <= if_gnt | dm_gnt;
            resp_owner_q <= dm_gnt;
            resp_we_q    <= dm_gnt & dm_we;
        end
    end

    // Route the one-cycle-late memory data to the owner; writes return zero data
    always_comb begin
        if_rvalid = resp_valid_q & ~resp_owner_q;
        dm_rvalid = resp_valid_q & resp_owner_q;
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        dm_rdata  = (dm_rvalid && !resp_we_q) ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        halt;
    logic        stall_if;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .halt(halt), .stall_if(stall_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: every access returns 0xC0DE0000 | addr one cycle later
    always @(posedge clk) begin
        mem_rdata <= mem_en ? (32'hC0DE_0000 | mem_addr) : 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Apply inputs at the falling edge, then settle
    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic h);
        @(negedge clk);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dwd;
        halt = h;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if_rvalid !== 1'b0) begin failures++; $display("FAIL reset_if_rvalid got=%b exp=0", if_rvalid); end
        checks++; if (dm_rvalid !== 1'b0) begin failures++; $display("FAIL reset_dm_rvalid got=%b exp=0", dm_rvalid); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem got en=%b addr=%h exp 0/0", mem_en, mem_addr); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            if (i < 4) begin
                checks++; if (if_gnt !== 1'b1 || stall_if !== 1'b0) begin failures++; $display("FAIL fetch_gnt[%0d] got gnt=%b stall=%b exp 1/0", i, if_gnt, stall_if); end
                checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'(4 * i)) begin failures++; $display("FAIL fetch_mem[%0d] got en=%b we=%b addr=%h exp 1/0/%h", i, mem_en, mem_we, mem_addr, 32'(4 * i)); end
            end
            if (i > 0) begin
                checks++; if (if_rvalid !== 1'b1 || if_rdata !== (32'hC0DE_0000 | 32'(4 * (i - 1)))) begin failures++; $display("FAIL fetch_rdata[%0d] got v=%b d=%h exp 1/%h", i, if_rvalid, if_rdata, 32'hC0DE_0000 | 32'(4 * (i - 1))); end
                checks++; if (dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL fetch_dm_quiet[%0d] got v=%b d=%h exp 0/0", i, dm_rvalid, dm_rdata); end
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_if;
        logic       prev_if;
        exp_if = 8'b1000_1000;  // bit i: fetch wins cycle i
        prev_if = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive(i < 8, 32'h40, i < 8, 1'b0, 32'h200, 32'h0, 1'b0);
            if (i < 8) begin
                checks++; if (if_gnt !== exp_if[i] || dm_gnt !== !exp_if[i] || stall_if !== !exp_if[i]) begin failures++; $display("FAIL contend_gnt[%0d] got if=%b dm=%b stall=%b exp if=%b", i, if_gnt, dm_gnt, stall_if, exp_if[i]); end
            end
            if (i > 0) begin
                prev_if = exp_if[i - 1];
                checks++;
                if (prev_if ? (if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE_0040 || dm_rvalid !== 1'b0)
                            : (dm_rvalid !== 1'b1 || dm_rdata !== 32'hC0DE_0200 || if_rvalid !== 1'b0)) begin
                    failures++;
                    $display("FAIL contend_resp[%0d] got ifv=%b ifd=%h dmv=%b dmd=%h exp if_owner=%b", i, if_rvalid, if_rdata, dm_rvalid, dm_rdata, prev_if);
                end
            end
        end
    endtask

    task automatic test_write_ack();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        checks++; if (dm_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_mem got gnt=%b en=%b we=%b addr=%h wd=%h exp 1/1/1/100/deadbeef", dm_gnt, mem_en, mem_we, mem_addr, mem_wdata); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'h0) begin failures++; $display("FAIL write_ack got v=%b d=%h exp 1/0", dm_rvalid, dm_rdata); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0) begin failures++; $display("FAIL idle_port got en=%b addr=%h wd=%h ifd=%h exp 0", mem_en, mem_addr, mem_wdata, if_rdata); end
    endtask

    task automatic test_interleave();
        for (int i = 0; i < 7; i++) begin
            drive(i < 6 && i % 2 == 0, 32'(32'h10 + 4 * i), i < 6 && i % 2 == 1, 1'b0, 32'(32'h300 + 4 * i), 32'h0, 1'b0);
            if (i > 0) begin
                checks++;
                if ((i - 1) % 2 == 0) begin
                    if (if_rvalid !== 1'b1 || if_rdata !== (32'hC0DE_0000 | 32'(32'h10 + 4 * (i - 1))) || dm_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin
                        failures++; $display("FAIL inter_if[%0d] got ifv=%b ifd=%h dmv=%b dmd=%h", i, if_rvalid, if_rdata, dm_rvalid, dm_rdata);
                    end
                end else begin
                    if (dm_rvalid !== 1'b1 || dm_rdata !== (32'hC0DE_0000 | 32'(32'h300 + 4 * (i - 1))) || if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin
                        failures++; $display("FAIL inter_dm[%0d] got ifv=%b ifd=%h dmv=%b dmd=%h", i, if_rvalid, if_rdata, dm_rvalid, dm_rdata);
                    end
                end
            end
        end
    endtask

    task automatic test_halt();
        // A: plain fetch; B: halt with contention (dm wins); C: halted, response still delivered
        drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h84, 1'b1, 1'b0, 32'h410, 32'h0, 1'b1);
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE_0080) begin failures++; $display("FAIL halt_cycle got dmg=%b ifg=%b ifv=%b ifd=%h exp 1/0/1/c0de0080", dm_gnt, if_gnt, if_rvalid, if_rdata); end
        drive(1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (if_gnt !== 1'b0 || stall_if !== 1'b1 || mem_en !== 1'b0) begin failures++; $display("FAIL halted_nogrant got ifg=%b stall=%b en=%b exp 0/1/0", if_gnt, stall_if, mem_en); end
        checks++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hC0DE_0410) begin failures++; $display("FAIL halted_dm_resp got v=%b d=%h exp 1/c0de0410", dm_rvalid, dm_rdata); end
        drive(1'b1, 32'h8C, 1'b1, 1'b0, 32'h420, 32'h0, 1'b0);
        checks++; if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h420) begin failures++; $display("FAIL halted_dm_served got dmg=%b ifg=%b addr=%h exp 1/0/420", dm_gnt, if_gnt, mem_addr); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            checks++; if (if_gnt !== 1'b0 || stall_if !== 1'b1) begin failures++; $display("FAIL halted_hold[%0d] got ifg=%b stall=%b exp 0/1", i, if_gnt, stall_if); end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        checks++; if (dm_rvalid !== 1'b1) begin failures++; $display("FAIL pre_reset_pending got v=%b exp 1", dm_rvalid); end
        dm_req = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL async_reset got dmv=%b ifv=%b dmd=%h exp 0/0/0", dm_rvalid, if_rvalid, dm_rdata); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h600;
        #1;
        checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin failures++; $display("FAIL post_release_rvalid got ifv=%b dmv=%b exp 0/0", if_rvalid, dm_rvalid); end
        checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h600) begin failures++; $display("FAIL first_grant got ifg=%b addr=%h exp 1/600", if_gnt, mem_addr); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hC0DE_0600) begin failures++; $display("FAIL first_resp got v=%b d=%h exp 1/c0de0600", if_rvalid, if_rdata); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin failures++; $display("FAIL single_pulse got ifv=%b dmv=%b exp 0/0", if_rvalid, dm_rvalid); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_contention();
        test_write_ack();
        test_interleave();
        test_halt();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
